mu0_io_responder: RTL and testbench

//  Memory-mapped peripheral responder on the MU0 memory bus. Sits beside mu0_memory and answers
//  Rd/Wr cycles from mu0 that fall in its 16-word address window.

---
 rtl/mu0_io_pkg.sv | 37 +++
 rtl/mu0_io_if.sv | 20 ++
 rtl/mu0_io_fifo.sv | 69 ++++++
 rtl/mu0_io_responder.sv | 128 ++++++++++++
 tb/tb_mu0_io_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mu0_io_pkg.sv
//------------------------------------------------------------------------------
// Module : mu0_io_pkg
// Brief  : Register map, STATUS layout and window width for the MU0 I/O responder.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mu0_io_pkg;

  localparam int WIN_W = 8;

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_RXDATA = 4'd2;
  localparam logic [3:0] OFF_TIMER  = 4'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_TX_COUNT_LSB = 8;

  typedef struct packed {
    logic [3:0] zero;
    logic [3:0] tx_count;
    logic [2:0] rsvd;
    logic       tx_overflow;
    logic       rx_overrun;
    logic       rx_valid;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

endpackage

`default_nettype wire

// File: rtl/mu0_io_if.sv
//------------------------------------------------------------------------------
// Module : mu0_io_if
// Brief  : MU0 memory-bus signals seen by a memory-mapped responder.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mu0_io_if;
  logic [11:0] Address;
  logic        Rd;
  logic        Wr;
  logic [15:0] Data_out;
  logic [15:0] Data_in;
  logic        Sel;

  modport master (output Address, Rd, Wr, Data_out, input Data_in, Sel);
  modport slave  (input Address, Rd, Wr, Data_out, output Data_in, Sel);
endinterface

`default_nettype wire

// File: rtl/mu0_io_fifo.sv
//------------------------------------------------------------------------------
// Module : mu0_io_fifo
// Brief  : Synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mu0_io_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic                     Clk,
  input  wire logic                     Reset,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic [DATA_W-1:0]        data_i,
  output logic      [DATA_W-1:0]        data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Empty head reads as zero so the stream output is clean after reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mu0_io_responder.sv
//------------------------------------------------------------------------------
// Module : mu0_io_responder
// Brief  : MU0 bus peripheral: TX FIFO, RX holding register, optional timer (MU0_IO_TIMER_EN).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mu0_io_responder
  import mu0_io_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = 12'hFF0,
  parameter int          FIFO_DEPTH = 4
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  mu0_io_if.slave          bus,
  output logic      [15:0] Tx_data,
  output logic             Tx_valid,
  input  wire logic        Tx_ready,
  input  wire logic [15:0] Rx_data,
  input  wire logic        Rx_strobe
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, wr_en, rd_en;
  logic [3:0]    off;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic          rx_read, overrun_evt;
  status_t       status;
  logic [15:0]   rd_data;

  logic [15:0]   rx_reg_q, rx_reg_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          tx_overflow_q, tx_overflow_d;

  assign hit   = (bus.Address[11 -: WIN_W] == BASE_ADDR[11 -: WIN_W]);
  assign off   = bus.Address[3:0];
  // Rd together with Wr is a write only.
  assign wr_en = bus.Wr & hit;
  assign rd_en = bus.Rd & ~bus.Wr & hit;

  assign bus.Sel     = (bus.Rd | bus.Wr) & hit;
  assign bus.Data_in = rd_data;

  assign tx_push  = wr_en & (off == OFF_TXDATA);
  assign tx_pop   = Tx_valid & Tx_ready;
  assign Tx_valid = ~tx_empty;

  mu0_io_fifo #(.DATA_W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (bus.Data_out),
    .data_o  (Tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign rx_read     = rd_en & (off == OFF_RXDATA);
  assign overrun_evt = Rx_strobe & rx_valid_q & ~rx_read;

  // Set events win over a simultaneous write-1-to-clear.
  always_comb begin
    rx_reg_d      = Rx_strobe ? Rx_data : rx_reg_q;
    rx_valid_d    = Rx_strobe ? 1'b1 : (rx_read ? 1'b0 : rx_valid_q);
    rx_overrun_d  = overrun_evt |
                    (rx_overrun_q & ~(wr_en & (off == OFF_STATUS) & bus.Data_out[ST_RX_OVERRUN]));
    tx_overflow_d = (tx_push & tx_full & ~tx_pop) |
                    (tx_overflow_q & ~(wr_en & (off == OFF_STATUS) & bus.Data_out[ST_TX_OVERFLOW]));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_reg_q      <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_reg_q      <= rx_reg_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

`ifdef MU0_IO_TIMER_EN
  logic [15:0] timer_q, timer_d;

  assign timer_d = (wr_en && off == OFF_TIMER) ? bus.Data_out : timer_q + 16'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  always_comb begin
    status             = '0;
    status.tx_full     = tx_full;
    status.tx_empty    = tx_empty;
    status.rx_valid    = rx_valid_q;
    status.rx_overrun  = rx_overrun_q;
    status.tx_overflow = tx_overflow_q;
    status.tx_count    = 4'(tx_count);
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (off)
        OFF_STATUS: rd_data = status;
        OFF_RXDATA: rd_data = rx_reg_q;
`ifdef MU0_IO_TIMER_EN
        OFF_TIMER:  rd_data = timer_q;
`endif
        default:    rd_data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mu0_io_responder.sv
//------------------------------------------------------------------------------
// Module : tb_mu0_io_responder
// Brief  : Directed bench for mu0_io_responder with a queue-based reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mu0_io_responder;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Tx_ready = 1'b0;
  logic        Rx_strobe = 1'b0;
  logic [15:0] Rx_data = 16'h0000;
  wire  [15:0] Tx_data;
  wire         Tx_valid;

  int n_tests = 0;
  int n_fail  = 0;

  mu0_io_if bus ();

  mu0_io_responder #(.BASE_ADDR(12'hFF0), .FIFO_DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Tx_data   (Tx_data),
    .Tx_valid  (Tx_valid),
    .Tx_ready  (Tx_ready),
    .Rx_data   (Rx_data),
    .Rx_strobe (Rx_strobe)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, flags as plain bits.
  logic [15:0] mq[$];
  bit          m_ovf, m_rxv, m_rxo;
  logic [15:0] m_rx, m_tmr;

  function automatic bit m_hit();
    return bus.Address[11:4] == 8'hFF;
  endfunction

  function automatic logic [15:0] m_status();
    return {4'h0, 4'(mq.size()), 3'b000, m_ovf, m_rxo, m_rxv,
            mq.size() == 0, mq.size() == DEPTH};
  endfunction

  function automatic logic [15:0] m_data_in();
    if (!(bus.Rd && !bus.Wr && m_hit())) return 16'h0000;
    case (bus.Address[3:0])
      4'd1:    return m_status();
      4'd2:    return m_rx;
`ifdef MU0_IO_TIMER_EN
      4'd3:    return m_tmr;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_ovf = 0; m_rxv = 0; m_rxo = 0;
      m_rx = 16'h0000; m_tmr = 16'h0000;
    end else begin
      automatic bit         wr   = bus.Wr && m_hit();
      automatic bit         rd   = bus.Rd && !bus.Wr && m_hit();
      automatic logic [3:0] off  = bus.Address[3:0];
      automatic bit         rdrx = rd && off == 4'd2;
      automatic bit         w1c  = wr && off == 4'd1;
      automatic bit         evt  = Rx_strobe && m_rxv && !rdrx;
      automatic bit         oset = 0;
      if (mq.size() > 0 && Tx_ready) void'(mq.pop_front());
      if (wr && off == 4'd0) begin
        if (mq.size() < DEPTH) mq.push_back(bus.Data_out);
        else oset = 1;
      end
      m_ovf = oset || (m_ovf && !(w1c && bus.Data_out[4]));
      m_rxo = evt  || (m_rxo && !(w1c && bus.Data_out[3]));
      if (Rx_strobe) begin m_rx = Rx_data; m_rxv = 1; end
      else if (rdrx) m_rxv = 0;
`ifdef MU0_IO_TIMER_EN
      m_tmr = (wr && off == 4'd3) ? bus.Data_out : m_tmr + 16'd1;
`endif
    end
  end

  always @(negedge Clk) begin
    chk("sel",      {15'd0, bus.Sel},  {15'd0, bus.Rd || bus.Wr ? m_hit() : 1'b0});
    chk("data_in",  bus.Data_in,       m_data_in());
    chk("tx_valid", {15'd0, Tx_valid}, {15'd0, mq.size() > 0});
    chk("tx_data",  Tx_data,           mq.size() > 0 ? mq[0] : 16'h0000);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setbus(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
    bus.Rd = rd; bus.Wr = wr; bus.Address = a; bus.Data_out = d;
  endtask

  task automatic idle();
    setbus(1'b0, 1'b0, 12'h000, 16'h0000);
  endtask

  initial begin
    idle();
    #1 Reset = 1'b1;
    #20 Reset = 1'b0;
    step();

    // Reset in the middle of a cycle with two words queued
    setbus(0, 1, 12'hFF0, 16'h1111); step();
    setbus(0, 1, 12'hFF0, 16'h2222); step();
    idle();
    #3 Reset = 1'b1;
    #1 chk("t1_txv", {15'd0, Tx_valid}, 16'h0000);
    chk("t1_txd", Tx_data, 16'h0000);
    #2 Reset = 1'b0;
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t1_status", bus.Data_in, 16'h0002);
    step();

    // Two pushes then drain
    setbus(0, 1, 12'hFF0, 16'h1111); step();
    setbus(0, 1, 12'hFF0, 16'h2222); step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t2_txv", {15'd0, Tx_valid}, 16'h0001);
    chk("t2_txd", Tx_data, 16'h1111);
    chk("t2_status", bus.Data_in, 16'h0200);
    idle(); Tx_ready = 1'b1;
    step();
    chk("t2_txd2", Tx_data, 16'h2222);
    step();
    chk("t2_empty", {15'd0, Tx_valid}, 16'h0000);
    Tx_ready = 1'b0;

    // Fill, overflow, W1C, push into full with pop
    for (int i = 0; i < 4; i++) begin
      setbus(0, 1, 12'hFF0, 16'hA000 + 16'(i)); step();
    end
    setbus(0, 1, 12'hFF0, 16'hDEAD); step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t3_ovf", bus.Data_in, 16'h0411);
    chk("t3_head", Tx_data, 16'hA000);
    step();
    setbus(0, 1, 12'hFF1, 16'h0010); step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t3_w1c", bus.Data_in, 16'h0401);
    step();
    setbus(0, 1, 12'hFF0, 16'hBEEF); Tx_ready = 1'b1; step();
    Tx_ready = 1'b0;
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t3_fullpush", bus.Data_in, 16'h0401);
    chk("t3_head2", Tx_data, 16'hA001);
    step();
    idle(); Tx_ready = 1'b1;
    repeat (4) step();
    Tx_ready = 1'b0;
    chk("t3_drained", {15'd0, Tx_valid}, 16'h0000);

    // RX overrun
    Rx_strobe = 1'b1; Rx_data = 16'hABCD; step();
    Rx_data = 16'h1234; step();
    Rx_strobe = 1'b0;
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t4_status", bus.Data_in, 16'h000E);
    step();
    setbus(1, 0, 12'hFF2, 16'h0000);
    #1 chk("t4_rx", bus.Data_in, 16'h1234);
    step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t4_cleared", bus.Data_in, 16'h000A);
    step();
    setbus(0, 1, 12'hFF1, 16'h0008); step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t4_w1c", bus.Data_in, 16'h0002);
    step();

    // W1C of overrun coincident with a new overrun keeps it set
    idle(); Rx_strobe = 1'b1; Rx_data = 16'h1111; step();
    setbus(0, 1, 12'hFF1, 16'h0008); Rx_data = 16'h2222; step();
    Rx_strobe = 1'b0;
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("w1c_race", bus.Data_in, 16'h000E);
    step();
    setbus(0, 1, 12'hFF1, 16'h0008); step();

    // Strobe coincident with RXDATA read
    setbus(1, 0, 12'hFF2, 16'h0000); Rx_strobe = 1'b1; Rx_data = 16'h5555;
    #1 chk("t5_old", bus.Data_in, 16'h2222);
    step();
    Rx_strobe = 1'b0;
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("t5_status", bus.Data_in, 16'h0006);
    step();
    setbus(1, 0, 12'hFF2, 16'h0000);
    #1 chk("t5_new", bus.Data_in, 16'h5555);
    step();

    // Rd&Wr on RXDATA acts as a write: reads 0, does not consume
    idle(); Rx_strobe = 1'b1; Rx_data = 16'h6666; step();
    Rx_strobe = 1'b0;
    setbus(1, 1, 12'hFF2, 16'h0000);
    #1 chk("rdwr_data", bus.Data_in, 16'h0000);
    chk("rdwr_sel", {15'd0, bus.Sel}, 16'h0001);
    step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("rdwr_status", bus.Data_in, 16'h0006);
    step();

    // Out-of-window write and unused offset
    setbus(0, 1, 12'hFE0, 16'h4321);
    #1 chk("miss_sel", {15'd0, bus.Sel}, 16'h0000);
    step();
    setbus(1, 0, 12'hFF1, 16'h0000);
    #1 chk("miss_status", bus.Data_in, 16'h0006);
    step();
    setbus(1, 0, 12'hFF5, 16'h0000);
    #1 chk("off5", bus.Data_in, 16'h0000);
    step();

    // Timer load and wrap
    setbus(0, 1, 12'hFF3, 16'hFFFE); step();
    setbus(1, 0, 12'hFF3, 16'h0000);
`ifdef MU0_IO_TIMER_EN
    #1 chk("tmr_load", bus.Data_in, 16'hFFFE);
    step();
    chk("tmr_ffff", bus.Data_in, 16'hFFFF);
    step();
    chk("tmr_wrap", bus.Data_in, 16'h0000);
`else
    #1 chk("tmr_off0", bus.Data_in, 16'h0000);
    step();
    chk("tmr_off1", bus.Data_in, 16'h0000);
`endif
    step();
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
